// File: rtl/dest_sel_pkg.sv
// Shared constants and helpers for the destination-select ring.
// Width helper, size limit and direction encodings.
package dest_sel_pkg;

  localparam int MAX_N = 16;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Ceiling log2 with a floor of one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/idx_onehot_dec.sv
// Binary index to one-hot select decoder.
// Purely combinational; the parent registers the result.
module idx_onehot_dec
  import dest_sel_pkg::*;
#(
  parameter int N = 3,
  parameter int W = clog2w(N)
) (
  input  logic [W-1:0] i_idx,
  output logic [N-1:0] o_sel
);

  // One bit per destination, set where the index matches.
  always_comb begin
    o_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (i_idx == W'(k)) o_sel[k] = 1'b1;
    end
  end

endmodule

// File: rtl/dest_sel_ring.sv
// Destination-select ring: binary index with loadable bound,
// wrap/saturate stepping and registered one-hot select.
module dest_sel_ring
  import dest_sel_pkg::*;
#(
  parameter int N         = 3,
  parameter int RESET_IDX = N - 1,
  parameter int WRAP      = 1,
  parameter int W         = clog2w(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LDD,
  input  logic         CLK1,
  input  logic         DIR,
  input  logic         LD_IDX,
  input  logic         LD_LAST,
  input  logic [W-1:0] IDX_I,
  output logic [N-1:0] SEL,
  output logic [W-1:0] IDX_O,
  output logic         WRAPPED,
  output logic         ERR
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("dest_sel_ring: N must be 2..16");
  end
  if (RESET_IDX < 0 || RESET_IDX >= N) begin : g_bad_rst
    $error("dest_sel_ring: RESET_IDX must be below N");
  end
  if (W < clog2w(N)) begin : g_bad_w
    $error("dest_sel_ring: W too narrow for N");
  end

  localparam logic [W-1:0] L_RST_IDX = W'(RESET_IDX);
  localparam logic [W-1:0] L_MAX     = W'(N - 1);
  localparam logic [W:0]   L_N       = (W + 1)'(N);
  localparam bit           L_WRAP    = (WRAP != 0);

  logic [W-1:0] r_idx;
  logic [W-1:0] r_last;
  logic [N-1:0] r_sel;
  logic         r_wrapped;
  logic         r_err;

  logic [W-1:0] w_idx_nxt;
  logic [W-1:0] w_last_nxt;
  logic         w_wrap_nxt;
  logic         w_err_nxt;
  logic [W-1:0] w_dec_in;
  logic [N-1:0] w_sel_nxt;

  logic w_do_last;
  logic w_do_idx;
  logic w_do_adv;
  logic w_last_bad;
  logic w_idx_bad;
  logic w_at_top;
  logic w_at_bot;

  assign w_do_last  = LD_LAST;
  assign w_do_idx   = LD_IDX & ~LD_LAST;
  assign w_do_adv   = LDD & ~CLK1 & ~LD_IDX & ~LD_LAST;
  assign w_last_bad = ({1'b0, IDX_I} >= L_N);
  assign w_idx_bad  = (IDX_I > r_last);
  assign w_at_top   = (r_idx >= r_last);
  assign w_at_bot   = (r_idx == '0);

  // Next index, bound, wrap pulse and error flag by priority.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_last_nxt = r_last;
    w_wrap_nxt = 1'b0;
    w_err_nxt  = r_err;
    unique case (1'b1)
      w_do_last: begin
        if (w_last_bad) begin
          w_err_nxt = 1'b1;
        end else begin
          w_last_nxt = IDX_I;
          if (r_idx > IDX_I) w_idx_nxt = IDX_I;
        end
      end
      w_do_idx: begin
        if (w_idx_bad) w_err_nxt = 1'b1;
        else           w_idx_nxt = IDX_I;
      end
      w_do_adv: begin
        if (DIR == DIR_UP) begin
          if (w_at_top) begin
            w_wrap_nxt = 1'b1;
            w_idx_nxt  = L_WRAP ? '0 : r_last;
          end else begin
            w_idx_nxt = r_idx + W'(1);
          end
        end else begin
          if (w_at_bot) begin
            w_wrap_nxt = 1'b1;
            w_idx_nxt  = L_WRAP ? r_last : '0;
          end else begin
            w_idx_nxt = r_idx - W'(1);
          end
        end
      end
      default: begin
        w_idx_nxt = r_idx;
      end
    endcase
  end

  assign w_dec_in = RST ? L_RST_IDX : w_idx_nxt;

  idx_onehot_dec #(
    .N (N),
    .W (W)
  ) u_dec (
    .i_idx (w_dec_in),
    .o_sel (w_sel_nxt)
  );

  // State register; reset overrides every strobe.
  always_ff @(posedge CLK) begin
    r_sel <= w_sel_nxt;
    if (RST) begin
      r_idx     <= L_RST_IDX;
      r_last    <= L_MAX;
      r_wrapped <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_last    <= w_last_nxt;
      r_wrapped <= w_wrap_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign SEL     = r_sel;
  assign IDX_O   = r_idx;
  assign WRAPPED = r_wrapped;
  assign ERR     = r_err;

endmodule
